// File: rtl/xor_stream_descrambler.sv
// Additive LFSR stream descrambler with a one-word output register and ready/valid handshake.
// Optional parity checking and error counter are compiled in with `define DESCR_PARITY_EN.
module xor_stream_descrambler #(
   parameter int          N    = 8,
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_data,
   input  logic          seed_load,
   input  logic [15:0]   seed_in
`ifdef DESCR_PARITY_EN
   ,
   input  logic          in_parity,
   output logic          out_perr,
   output logic [7:0]    err_count
`endif
);

   logic [15:0]  lfsr_q, lfsr_d, lfsr_adv;
   logic [N-1:0] key;
   logic [N-1:0] descr;
   logic         out_valid_q, out_valid_d;
   logic [N-1:0] out_data_q, out_data_d;
   logic         xfer;

   assign in_ready = !out_valid_q || out_ready;
   assign xfer     = in_valid && in_ready;
   assign descr    = in_data ^ key;

   // Walk the LFSR N steps from the current state; key bit i is S[15] before step i.
   always_comb begin
      logic [15:0] walk;
      key  = '0;
      walk = lfsr_q;
      for (int i = 0; i < N; i++) begin
         key[i] = walk[15];
         walk   = {walk[14:0], walk[15] ^ walk[13] ^ walk[12] ^ walk[10]};
      end
      lfsr_adv = walk;
   end

   // A reload beats the per-word advance; an all-zero seed would lock the LFSR up.
   always_comb begin
      lfsr_d = lfsr_q;
      if (seed_load) begin
         lfsr_d = (seed_in == 16'h0000) ? 16'h0001 : seed_in;
      end else if (xfer) begin
         lfsr_d = lfsr_adv;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = descr;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q      <= SEED;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         lfsr_q      <= lfsr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

`ifdef DESCR_PARITY_EN
   logic       perr_q, perr_d;
   logic [7:0] err_count_q, err_count_d;
   logic       mismatch;

   assign mismatch = (^descr) != in_parity;

   always_comb begin
      perr_d      = perr_q;
      err_count_d = err_count_q;
      if (xfer) begin
         perr_d = mismatch;
         if (mismatch && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perr_q      <= 1'b0;
         err_count_q <= 8'd0;
      end else begin
         perr_q      <= perr_d;
         err_count_q <= err_count_d;
      end
   end

   assign out_perr  = perr_q;
   assign err_count = err_count_q;
`endif

endmodule
